// File: rtl/vend_core.sv
// Vending transaction controller: channel selection, multi-quantity payment, change and admin restock.
// Optional SALES_STATS_EN adds per-channel sold counters and a revenue accumulator.
module vend_core #(
  parameter int CHANNELS   = 12,
  parameter int STOCK_W    = 6,
  parameter int PRICE_W    = 11,
  parameter int QTY_MAX    = 4,
  parameter int INIT_STOCK = 5,
  parameter int INIT_PRICE = 35,
  parameter int TIMEOUT    = 1000,
  localparam int CH_W  = $clog2(CHANNELS),
  localparam int QTY_W = $clog2(QTY_MAX + 1),
  localparam int TMR_W = $clog2(TIMEOUT + 1),
  localparam int AW    = PRICE_W + QTY_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               sel_next,
  input  logic               sel_prev,
  input  logic               qty_up,
  input  logic               qty_dn,
  input  logic               confirm,
  input  logic               cancel,
  input  logic               coin5,
  input  logic               coin10,
  input  logic               coin100,
  input  logic               admin_mode,
  input  logic               restock,
  input  logic               price_we,
  input  logic [CH_W-1:0]    price_addr,
  input  logic [PRICE_W-1:0] price_data,
  output logic [2:0]         state,
  output logic [CH_W-1:0]    channel,
  output logic [STOCK_W-1:0] stock,
  output logic [QTY_W-1:0]   qty,
  output logic [AW-1:0]      due,
  output logic [AW-1:0]      paid,
  output logic [TMR_W-1:0]   timer,
  output logic [AW-1:0]      change,
  output logic               change_valid,
  output logic               vend_valid,
  output logic [CH_W-1:0]    vend_channel,
  output logic [QTY_W-1:0]   vend_qty,
  output logic               all_empty
`ifdef SALES_STATS_EN
  ,
  input  logic [CH_W-1:0]    stat_addr,
  output logic [15:0]        sold_cnt,
  output logic [23:0]        revenue
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_PAY     = 3'd2;
  localparam logic [2:0] S_VEND    = 3'd3;
  localparam logic [2:0] S_REFUND  = 3'd4;
  localparam logic [2:0] S_RESTOCK = 3'd5;
  localparam int AW1 = AW + 1;

  logic [STOCK_W-1:0] stock_mem [CHANNELS];
  logic [PRICE_W-1:0] price_mem [CHANNELS];
  logic [CH_W-1:0]    next_stocked, prev_stocked, sel_tgt;
  logic [AW1-1:0]     coin_amt, paid_sum;
  logic [AW-1:0]      paid_new;
  logic [TMR_W-1:0]   timer_new;
  logic               coin_any, any_sel;

  function automatic logic [CH_W-1:0] wrap_ch(input logic [CH_W-1:0] c, input int off);
    int t;
    t = (int'(c) + off) % CHANNELS;
    return CH_W'(t);
  endfunction

  assign stock   = stock_mem[channel];
  assign due     = AW'(qty) * AW'(price_mem[channel]);
  assign any_sel = sel_next | sel_prev | qty_up | qty_dn | confirm;
  assign sel_tgt = sel_next ? next_stocked : prev_stocked;

  always_comb begin
    all_empty = 1'b1;
    for (int i = 0; i < CHANNELS; i++)
      if (stock_mem[i] != '0) all_empty = 1'b0;
  end

  // Descending scan so the nearest stocked neighbour is the last assignment; none found -> hold.
  always_comb begin
    next_stocked = channel;
    prev_stocked = channel;
    for (int i = CHANNELS - 1; i >= 1; i--) begin
      if (stock_mem[wrap_ch(channel, i)] != '0) next_stocked = wrap_ch(channel, i);
      if (stock_mem[wrap_ch(channel, CHANNELS - i)] != '0) prev_stocked = wrap_ch(channel, CHANNELS - i);
    end
  end

  always_comb begin
    coin_any = coin5 | coin10 | coin100;
    coin_amt = (coin5 ? AW1'(5) : '0) + (coin10 ? AW1'(10) : '0) + (coin100 ? AW1'(100) : '0);
    paid_sum = {1'b0, paid} + coin_amt;
    paid_new = paid_sum[AW] ? '1 : paid_sum[AW-1:0];
    if (coin_any) timer_new = TMR_W'(TIMEOUT);
    else if (tick && timer != '0) timer_new = timer - TMR_W'(1);
    else timer_new = timer;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      channel      <= '0;
      qty          <= QTY_W'(1);
      paid         <= '0;
      timer        <= '0;
      change       <= '0;
      change_valid <= 1'b0;
      vend_valid   <= 1'b0;
      vend_channel <= '0;
      vend_qty     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        stock_mem[i] <= STOCK_W'(INIT_STOCK);
        price_mem[i] <= PRICE_W'(INIT_PRICE);
      end
    end else begin
      change_valid <= 1'b0;
      vend_valid   <= 1'b0;
      case (state)
        S_IDLE, S_SELECT: begin
          if (admin_mode) state <= S_RESTOCK;
          else if (state == S_SELECT && cancel) state <= S_IDLE;
          else if (state == S_SELECT || any_sel) begin
            state <= S_SELECT;
            // An empty current channel is skipped before any pulse is honoured.
            if (stock_mem[channel] == '0) begin
              if (!all_empty) begin
                channel <= next_stocked;
                qty     <= QTY_W'(1);
              end
            end else if (sel_next ^ sel_prev) begin
              if (sel_tgt != channel) begin
                channel <= sel_tgt;
                qty     <= QTY_W'(1);
              end
            end else if (qty_up && !qty_dn) begin
              if (int'(qty) < QTY_MAX && int'(qty) < int'(stock_mem[channel]))
                qty <= qty + QTY_W'(1);
            end else if (qty_dn && !qty_up) begin
              if (qty > QTY_W'(1)) qty <= qty - QTY_W'(1);
            end else if (confirm && int'(stock_mem[channel]) >= int'(qty)) begin
              state  <= S_PAY;
              paid   <= '0;
              timer  <= TMR_W'(TIMEOUT);
              change <= '0;
            end
          end
        end
        S_PAY: begin
          paid  <= paid_new;
          timer <= timer_new;
          if (cancel) begin
            state        <= S_REFUND;
            change       <= paid_new;
            change_valid <= 1'b1;
          end else if (paid_new >= due) begin
            state        <= S_VEND;
            change       <= paid_new - due;
            change_valid <= 1'b1;
            vend_valid   <= 1'b1;
            vend_channel <= channel;
            vend_qty     <= qty;
          end else if (timer_new == '0) begin
            state        <= S_REFUND;
            change       <= paid_new;
            change_valid <= 1'b1;
          end
        end
        S_VEND: begin
          stock_mem[channel] <= stock_mem[channel] - STOCK_W'(qty);
          qty                <= QTY_W'(1);
          state              <= S_SELECT;
        end
        S_REFUND: begin
          paid  <= '0;
          state <= S_SELECT;
        end
        S_RESTOCK: begin
          if (!admin_mode || cancel) state <= S_IDLE;
          if (sel_next && !sel_prev) begin
            channel <= (channel == CH_W'(CHANNELS - 1)) ? '0 : channel + CH_W'(1);
            qty     <= QTY_W'(1);
          end else if (sel_prev && !sel_next) begin
            channel <= (channel == '0) ? CH_W'(CHANNELS - 1) : channel - CH_W'(1);
            qty     <= QTY_W'(1);
          end
          if (restock && stock_mem[channel] != '1)
            stock_mem[channel] <= stock_mem[channel] + STOCK_W'(1);
          if (price_we && int'(price_addr) < CHANNELS)
            price_mem[price_addr] <= price_data;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SALES_STATS_EN
  logic [15:0] sold_mem [CHANNELS];
  logic [23:0] revenue_q;
  logic [16:0] sold_sum;
  logic [24:0] rev_sum;

  assign sold_sum = {1'b0, sold_mem[channel]} + 17'(vend_qty);
  assign rev_sum  = {1'b0, revenue_q} + 25'(due);
  assign sold_cnt = (int'(stat_addr) < CHANNELS) ? sold_mem[stat_addr] : '0;
  assign revenue  = revenue_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      revenue_q <= '0;
      for (int i = 0; i < CHANNELS; i++) sold_mem[i] <= '0;
    end else if (state == S_VEND) begin
      sold_mem[channel] <= sold_sum[16] ? '1 : sold_sum[15:0];
      revenue_q         <= rev_sum[24] ? '1 : rev_sum[23:0];
    end
  end
`endif

endmodule

// File: tb/tb_vend_core.sv
// Directed bench for vend_core: selection, payment, timeout, refund, drain and admin restock.
module tb_vend_core;
  logic        clk = 1'b0;
  logic        rst, tick, sel_next, sel_prev, qty_up, qty_dn, confirm, cancel;
  logic        coin5, coin10, coin100, admin_mode, restock, price_we;
  logic [3:0]  price_addr;
  logic [10:0] price_data;
  logic [2:0]  state;
  logic [3:0]  channel, vend_channel;
  logic [5:0]  stock;
  logic [2:0]  qty, vend_qty;
  logic [13:0] due, paid, change;
  logic [9:0]  timer;
  logic        change_valid, vend_valid, all_empty;
`ifdef SALES_STATS_EN
  logic [3:0]  stat_addr = '0;
  logic [15:0] sold_cnt;
  logic [23:0] revenue;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vend_core dut (
    .clk(clk), .rst(rst), .tick(tick), .sel_next(sel_next), .sel_prev(sel_prev),
    .qty_up(qty_up), .qty_dn(qty_dn), .confirm(confirm), .cancel(cancel),
    .coin5(coin5), .coin10(coin10), .coin100(coin100), .admin_mode(admin_mode),
    .restock(restock), .price_we(price_we), .price_addr(price_addr), .price_data(price_data),
    .state(state), .channel(channel), .stock(stock), .qty(qty), .due(due), .paid(paid),
    .timer(timer), .change(change), .change_valid(change_valid), .vend_valid(vend_valid),
    .vend_channel(vend_channel), .vend_qty(vend_qty), .all_empty(all_empty)
`ifdef SALES_STATS_EN
    , .stat_addr(stat_addr), .sold_cnt(sold_cnt), .revenue(revenue)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    tick = 0; sel_next = 0; sel_prev = 0; qty_up = 0; qty_dn = 0; confirm = 0; cancel = 0;
    coin5 = 0; coin10 = 0; coin100 = 0; restock = 0; price_we = 0;
  endtask

  task automatic pulse_cycle();
    step();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    admin_mode = 0; price_addr = '0; price_data = '0;
    rst = 1; step(); step(); rst = 0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (channel !== 4'd0) begin errors++; $display("FAIL reset_channel: got %0d want 0", channel); end
    checks++; if (qty !== 3'd1) begin errors++; $display("FAIL reset_qty: got %0d want 1", qty); end
    checks++; if (paid !== 14'd0 || timer !== 10'd0 || change !== 14'd0) begin errors++; $display("FAIL reset_regs: paid=%0d timer=%0d change=%0d want 0", paid, timer, change); end
    checks++; if (vend_valid !== 1'b0 || change_valid !== 1'b0) begin errors++; $display("FAIL reset_pulses: vend=%0b chg=%0b want 0", vend_valid, change_valid); end
    checks++; if (stock !== 6'd5 || due !== 14'd35 || all_empty !== 1'b0) begin errors++; $display("FAIL reset_tables: stock=%0d due=%0d empty=%0b want 5/35/0", stock, due, all_empty); end
  endtask

  task automatic test_basic_vend();
    repeat (3) begin sel_next = 1; pulse_cycle(); end
    checks++; if (state !== 3'd1 || channel !== 4'd3) begin errors++; $display("FAIL sel_ch3: state=%0d ch=%0d want 1/3", state, channel); end
    checks++; if (stock !== 6'd5 || qty !== 3'd1 || due !== 14'd35) begin errors++; $display("FAIL sel_ch3_info: stock=%0d qty=%0d due=%0d want 5/1/35", stock, qty, due); end
    coin100 = 1; pulse_cycle();
    checks++; if (paid !== 14'd0) begin errors++; $display("FAIL coin_outside_pay: got %0d want 0", paid); end
    confirm = 1; pulse_cycle();
    checks++; if (state !== 3'd2 || timer !== 10'd1000 || paid !== 14'd0) begin errors++; $display("FAIL pay_entry: state=%0d timer=%0d paid=%0d want 2/1000/0", state, timer, paid); end
    repeat (3) begin coin10 = 1; pulse_cycle(); end
    checks++; if (state !== 3'd2 || paid !== 14'd30) begin errors++; $display("FAIL pay_30: state=%0d paid=%0d want 2/30", state, paid); end
    coin10 = 1; pulse_cycle();
    checks++; if (state !== 3'd3 || vend_valid !== 1'b1 || vend_channel !== 4'd3 || vend_qty !== 3'd1) begin errors++; $display("FAIL vend_ch3: state=%0d v=%0b ch=%0d q=%0d want 3/1/3/1", state, vend_valid, vend_channel, vend_qty); end
    checks++; if (change !== 14'd5 || change_valid !== 1'b1) begin errors++; $display("FAIL vend_ch3_change: change=%0d cv=%0b want 5/1", change, change_valid); end
    step();
    checks++; if (state !== 3'd1 || stock !== 6'd4 || vend_valid !== 1'b0 || change_valid !== 1'b0) begin errors++; $display("FAIL after_vend_ch3: state=%0d stock=%0d v=%0b cv=%0b want 1/4/0/0", state, stock, vend_valid, change_valid); end
    checks++; if (change !== 14'd5) begin errors++; $display("FAIL change_held: got %0d want 5", change); end
  endtask

  task automatic test_multi_qty();
    repeat (3) begin sel_prev = 1; pulse_cycle(); end
    repeat (5) begin qty_up = 1; pulse_cycle(); end
    checks++; if (channel !== 4'd0 || qty !== 3'd4 || due !== 14'd140) begin errors++; $display("FAIL qty_cap: ch=%0d qty=%0d due=%0d want 0/4/140", channel, qty, due); end
    qty_dn = 1; pulse_cycle();
    checks++; if (qty !== 3'd3) begin errors++; $display("FAIL qty_dn: got %0d want 3", qty); end
    qty_up = 1; pulse_cycle();
    confirm = 1; pulse_cycle();
    coin100 = 1; coin10 = 1; coin5 = 1; pulse_cycle();
    checks++; if (paid !== 14'd115 || state !== 3'd2) begin errors++; $display("FAIL coin_sum: paid=%0d state=%0d want 115/2", paid, state); end
    coin5 = 1; pulse_cycle();
    checks++; if (paid !== 14'd120 || vend_valid !== 1'b0) begin errors++; $display("FAIL paid_120: paid=%0d v=%0b want 120/0", paid, vend_valid); end
    coin10 = 1; pulse_cycle();
    coin10 = 1; pulse_cycle();
    checks++; if (vend_valid !== 1'b1 || vend_qty !== 3'd4 || vend_channel !== 4'd0 || change !== 14'd0) begin errors++; $display("FAIL vend_qty4: v=%0b q=%0d ch=%0d change=%0d want 1/4/0/0", vend_valid, vend_qty, vend_channel, change); end
    step();
    checks++; if (stock !== 6'd1 || qty !== 3'd1) begin errors++; $display("FAIL stock_after_qty4: stock=%0d qty=%0d want 1/1", stock, qty); end
  endtask

  task automatic test_timeout();
    confirm = 1; pulse_cycle();
    coin5 = 1; pulse_cycle();
    checks++; if (paid !== 14'd5 || timer !== 10'd1000) begin errors++; $display("FAIL timeout_coin: paid=%0d timer=%0d want 5/1000", paid, timer); end
    tick = 1; repeat (999) step(); tick = 0;
    checks++; if (state !== 3'd2 || timer !== 10'd1) begin errors++; $display("FAIL timeout_999: state=%0d timer=%0d want 2/1", state, timer); end
    tick = 1; pulse_cycle();
    checks++; if (state !== 3'd4 || change !== 14'd5 || change_valid !== 1'b1 || vend_valid !== 1'b0) begin errors++; $display("FAIL timeout_refund: state=%0d change=%0d cv=%0b v=%0b want 4/5/1/0", state, change, change_valid, vend_valid); end
    step();
    checks++; if (state !== 3'd1 || change_valid !== 1'b0 || paid !== 14'd0) begin errors++; $display("FAIL timeout_return: state=%0d cv=%0b paid=%0d want 1/0/0", state, change_valid, paid); end
  endtask

  task automatic test_cancel_coin();
    confirm = 1; pulse_cycle();
    cancel = 1; coin100 = 1; pulse_cycle();
    checks++; if (state !== 3'd4 || change !== 14'd100 || change_valid !== 1'b1) begin errors++; $display("FAIL cancel_coin: state=%0d change=%0d cv=%0b want 4/100/1", state, change, change_valid); end
    step();
    checks++; if (state !== 3'd1 || stock !== 6'd1) begin errors++; $display("FAIL cancel_return: state=%0d stock=%0d want 1/1", state, stock); end
  endtask

  task automatic test_drain();
    sel_next = 1; pulse_cycle();
    repeat (5) begin qty_up = 1; pulse_cycle(); end
    confirm = 1; pulse_cycle();
    coin100 = 1; pulse_cycle();
    coin100 = 1; pulse_cycle();
    checks++; if (vend_valid !== 1'b1 || vend_channel !== 4'd1 || vend_qty !== 3'd4 || change !== 14'd60) begin errors++; $display("FAIL ch1_buy4: v=%0b ch=%0d q=%0d change=%0d want 1/1/4/60", vend_valid, vend_channel, vend_qty, change); end
    step();
    confirm = 1; pulse_cycle();
    coin100 = 1; pulse_cycle();
    checks++; if (vend_valid !== 1'b1 || vend_qty !== 3'd1 || change !== 14'd65) begin errors++; $display("FAIL ch1_buy1: v=%0b q=%0d change=%0d want 1/1/65", vend_valid, vend_qty, change); end
    step(); step();
    checks++; if (channel !== 4'd2 || qty !== 3'd1 || stock !== 6'd5) begin errors++; $display("FAIL auto_advance: ch=%0d qty=%0d stock=%0d want 2/1/5", channel, qty, stock); end
  endtask

  task automatic test_drain_all();
    int total, q, guard;
    total = 0; guard = 0;
    while (!all_empty && guard < 40) begin
      guard++;
      q = (stock > 6'd4) ? 4 : int'(stock);
      if (q < 1) q = 1;
      repeat (q - 1) begin qty_up = 1; pulse_cycle(); end
      confirm = 1; pulse_cycle();
      for (int k = 0; k < 4 && state == 3'd2; k++) begin
        coin100 = 1; pulse_cycle();
        if (vend_valid) total += int'(vend_qty);
      end
      step(); step();
    end
    checks++; if (all_empty !== 1'b1) begin errors++; $display("FAIL all_empty: got %0b want 1 after %0d buys", all_empty, guard); end
    checks++; if (total != 50) begin errors++; $display("FAIL drain_total: got %0d want 50", total); end
    checks++; if (channel !== 4'd0) begin errors++; $display("FAIL drain_last_ch: got %0d want 0", channel); end
    sel_next = 1; pulse_cycle();
    confirm = 1; pulse_cycle();
    checks++; if (channel !== 4'd0 || state !== 3'd1) begin errors++; $display("FAIL empty_hold: ch=%0d state=%0d want 0/1", channel, state); end
  endtask

  task automatic test_admin();
    admin_mode = 1; step();
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL restock_entry: got %0d want 5", state); end
    sel_prev = 1; pulse_cycle();
    checks++; if (channel !== 4'd11 || stock !== 6'd0) begin errors++; $display("FAIL restock_wrap: ch=%0d stock=%0d want 11/0", channel, stock); end
    repeat (70) begin restock = 1; pulse_cycle(); end
    checks++; if (stock !== 6'd63 || all_empty !== 1'b0) begin errors++; $display("FAIL restock_sat: stock=%0d empty=%0b want 63/0", stock, all_empty); end
    price_addr = 4'd11; price_data = 11'd500; price_we = 1; pulse_cycle();
    admin_mode = 0; step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL admin_exit: got %0d want 0", state); end
    sel_next = 1; pulse_cycle();
    checks++; if (state !== 3'd1 || channel !== 4'd11 || due !== 14'd500) begin errors++; $display("FAIL new_price: state=%0d ch=%0d due=%0d want 1/11/500", state, channel, due); end
    price_addr = 4'd11; price_data = 11'd77; price_we = 1; pulse_cycle();
    qty_up = 1; pulse_cycle();
    checks++; if (qty !== 3'd2 || due !== 14'd1000) begin errors++; $display("FAIL price_we_ignored: qty=%0d due=%0d want 2/1000", qty, due); end
  endtask

  initial begin
    test_reset();
    test_basic_vend();
    test_multi_qty();
    test_timeout();
    test_cancel_coin();
    test_drain();
    test_drain_all();
    test_admin();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
